// File: rtl/cc_speed_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cc_speed_tick_gen
//  Description : Programmable game-speed tick generator. Accel/brake presses
//                step a saturating level; the tick period shrinks as it rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_speed_tick_gen #(
    parameter int DATAWIDTH   = 23,
    parameter int LEVELBITS   = 3,
    parameter int LEVELS      = 8,
    parameter int PERIOD_MAX  = 8388607,
    parameter int PERIOD_STEP = 1048576
) (
    input  logic                 CC_SPEEDTICK_CLOCK_50,
    input  logic                 CC_SPEEDTICK_RESET_InHigh,
    input  logic                 CC_SPEEDTICK_accel_InHigh,
    input  logic                 CC_SPEEDTICK_brake_InHigh,
    input  logic                 CC_SPEEDTICK_pause_InHigh,
    input  logic                 CC_SPEEDTICK_clear_InHigh,
    output logic                 CC_SPEEDTICK_T0_OutLow,
    output logic [LEVELBITS-1:0] CC_SPEEDTICK_level_OutBUS,
    output logic [DATAWIDTH-1:0] CC_SPEEDTICK_count_OutBUS
);

    localparam logic [DATAWIDTH-1:0] c_periodMax  = DATAWIDTH'(PERIOD_MAX);
    localparam logic [DATAWIDTH-1:0] c_periodStep = DATAWIDTH'(PERIOD_STEP);
    localparam logic [DATAWIDTH-1:0] c_countOne   = DATAWIDTH'(1);
    localparam logic [LEVELBITS-1:0] c_levelMax   = LEVELBITS'(LEVELS - 1);
    localparam logic [LEVELBITS-1:0] c_levelOne   = LEVELBITS'(1);
    localparam logic [LEVELBITS-1:0] c_levelZero  = '0;

    logic                 r_accelPrev;
    logic                 r_brakePrev;
    logic [LEVELBITS-1:0] r_level;
    logic [DATAWIDTH-1:0] r_count;
    logic                 r_tickN;

    logic                 w_accelRise;
    logic                 w_brakeRise;
    logic [LEVELBITS-1:0] w_levelNext;
    logic [DATAWIDTH-1:0] w_levelMinusOne;
    logic [DATAWIDTH-1:0] w_term;

    assign w_accelRise = CC_SPEEDTICK_accel_InHigh & ~r_accelPrev;
    assign w_brakeRise = CC_SPEEDTICK_brake_InHigh & ~r_brakePrev;

    // Value is meaningless at level 0; the counter ignores it there.
    assign w_levelMinusOne = DATAWIDTH'(r_level) - c_countOne;
    assign w_term          = c_periodMax - (w_levelMinusOne * c_periodStep);

    always_comb begin
        w_levelNext = r_level;
        if (CC_SPEEDTICK_clear_InHigh) begin
            w_levelNext = c_levelZero;
        end else if (w_accelRise && w_brakeRise) begin
            w_levelNext = r_level;
        end else if (w_accelRise) begin
            if (r_level != c_levelMax) begin
                w_levelNext = r_level + c_levelOne;
            end
        end else if (w_brakeRise) begin
            if (r_level != c_levelZero) begin
                w_levelNext = r_level - c_levelOne;
            end
        end
    end

    // Counter uses the level held before this edge, so a level change
    // takes effect on the compare one cycle later without resetting count.
    always_ff @(posedge CC_SPEEDTICK_CLOCK_50 or posedge CC_SPEEDTICK_RESET_InHigh) begin
        if (CC_SPEEDTICK_RESET_InHigh) begin
            r_accelPrev <= 1'b0;
            r_brakePrev <= 1'b0;
            r_level     <= '0;
            r_count     <= '0;
            r_tickN     <= 1'b1;
        end else begin
            r_accelPrev <= CC_SPEEDTICK_accel_InHigh;
            r_brakePrev <= CC_SPEEDTICK_brake_InHigh;
            r_level     <= w_levelNext;
            if (CC_SPEEDTICK_clear_InHigh || (r_level == c_levelZero)) begin
                r_count <= '0;
                r_tickN <= 1'b1;
            end else if (CC_SPEEDTICK_pause_InHigh) begin
                r_count <= r_count;
                r_tickN <= 1'b1;
            end else if (r_count >= w_term) begin
                r_count <= '0;
                r_tickN <= 1'b0;
            end else begin
                r_count <= r_count + c_countOne;
                r_tickN <= 1'b1;
            end
        end
    end

    assign CC_SPEEDTICK_T0_OutLow    = r_tickN;
    assign CC_SPEEDTICK_level_OutBUS = r_level;
    assign CC_SPEEDTICK_count_OutBUS = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cc_speed_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cc_speed_tick_gen
//  Description : Directed self-checking bench for cc_speed_tick_gen
//                (DATAWIDTH=4, LEVELS=4, TERM 15/13/11).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_speed_tick_gen;

    logic       clk;
    logic       rst;
    logic       accel;
    logic       brake;
    logic       pause;
    logic       clear;
    logic       tickN;
    logic [1:0] level;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;
    int period;
    int sawLow;

    cc_speed_tick_gen #(
        .DATAWIDTH  (4),
        .LEVELBITS  (2),
        .LEVELS     (4),
        .PERIOD_MAX (15),
        .PERIOD_STEP(2)
    ) dut (
        .CC_SPEEDTICK_CLOCK_50    (clk),
        .CC_SPEEDTICK_RESET_InHigh(rst),
        .CC_SPEEDTICK_accel_InHigh(accel),
        .CC_SPEEDTICK_brake_InHigh(brake),
        .CC_SPEEDTICK_pause_InHigh(pause),
        .CC_SPEEDTICK_clear_InHigh(clear),
        .CC_SPEEDTICK_T0_OutLow   (tickN),
        .CC_SPEEDTICK_level_OutBUS(level),
        .CC_SPEEDTICK_count_OutBUS(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pressAccel();
        accel = 1'b1;
        @(negedge clk);
        accel = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitCount(input string tag, input logic [3:0] value);
        int n = 0;
        while (count !== value && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(tag, count, value);
    endtask

    task automatic waitTick(input string tag);
        int n = 0;
        while (tickN !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(tag, tickN, 1'b0);
    endtask

    // Negedges from one low tick to the next.
    task automatic measurePeriod(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tickN !== 1'b0 && n < 64);
    endtask

    initial begin
        rst = 1'b1; accel = 1'b0; brake = 1'b0; pause = 1'b0; clear = 1'b0;
        @(negedge clk);
        check("reset_tick", tickN, 1'b1);
        check("reset_level", level, 0);
        check("reset_count", count, 0);
        rst = 1'b0;

        // 1: single press to level 1, 16-cycle period
        accel = 1'b1;
        @(negedge clk);
        accel = 1'b0;
        check("t1_level", level, 1);
        check("t1_count0", count, 0);
        repeat (15) @(negedge clk);
        check("t1_count15", count, 15);
        check("t1_tick_hi", tickN, 1'b1);
        @(negedge clk);
        check("t1_wrap_count", count, 0);
        check("t1_wrap_tick", tickN, 1'b0);
        measurePeriod(period);
        check("t1_period", period, 16);

        // 2: held accel steps once; saturation at level 3
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t2_clr_level", level, 0);
        accel = 1'b1;
        repeat (10) @(negedge clk);
        check("t2_held_level", level, 1);
        accel = 1'b0;
        @(negedge clk);
        pressAccel();
        pressAccel();
        pressAccel();
        check("t2_sat_level", level, 3);
        waitTick("t2_sync");
        measurePeriod(period);
        check("t2_period", period, 12);
        check("t2_level_stays", level, 3);

        // 3: level change mid-period with count above new TERM
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        pressAccel();
        check("t3_level1", level, 1);
        waitCount("t3_at14", 14);
        accel = 1'b1;
        @(negedge clk);
        accel = 1'b0;
        check("t3_level2", level, 2);
        check("t3_count15", count, 15);
        check("t3_tick_hi", tickN, 1'b1);
        @(negedge clk);
        check("t3_fire_tick", tickN, 1'b0);
        check("t3_fire_count", count, 0);
        measurePeriod(period);
        check("t3_period", period, 14);

        // 4: simultaneous accel/brake, then clear mid-period
        accel = 1'b1;
        brake = 1'b1;
        @(negedge clk);
        accel = 1'b0;
        brake = 1'b0;
        check("t4_both_level", level, 2);
        waitCount("t4_at7", 7);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t4_clr_level", level, 0);
        check("t4_clr_count", count, 0);
        sawLow = 0;
        repeat (20) begin
            @(negedge clk);
            if (tickN !== 1'b1) sawLow++;
        end
        check("t4_no_ticks", sawLow, 0);
        check("t4_count_idle", count, 0);

        // 5: pause holds count and suppresses ticks
        pressAccel();
        waitCount("t5_at5", 5);
        pause = 1'b1;
        sawLow = 0;
        repeat (7) begin
            @(negedge clk);
            if (tickN !== 1'b1) sawLow++;
        end
        check("t5_pause_count", count, 5);
        check("t5_pause_ticks", sawLow, 0);
        pause = 1'b0;
        @(negedge clk);
        check("t5_resume6", count, 6);
        @(negedge clk);
        check("t5_resume7", count, 7);
        waitTick("t5_sync");
        measurePeriod(period);
        check("t5_period", period, 16);

        // brake to level 0, and brake saturating at 0
        brake = 1'b1;
        @(negedge clk);
        brake = 1'b0;
        check("brk_level0", level, 0);
        @(negedge clk);
        check("brk_count0", count, 0);
        brake = 1'b1;
        @(negedge clk);
        brake = 1'b0;
        check("brk_sat_level", level, 0);

        // 6: async reset between edges; accel high at release counts
        pressAccel();
        pressAccel();
        check("t6_level2", level, 2);
        waitCount("t6_at9", 9);
        #2 rst = 1'b1;
        #1;
        check("t6_async_tick", tickN, 1'b1);
        check("t6_async_level", level, 0);
        check("t6_async_count", count, 0);
        accel = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_release_level", level, 1);
        check("t6_release_count", count, 0);
        accel = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_no_restep", level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
